// File: rtl/tim_apb_arb.sv
// tim_apb_arb: round-robin two-master APB arbiter with TIPC security filter in front of a zero-wait timer slave.
// Blocked accesses answer immediately with pslverr and never reach the timer.
module tim_apb_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              tipc_tim_trust,
  input  logic              m0_psel,
  input  logic              m0_penable,
  input  logic [ADDR_W-1:0] m0_paddr,
  input  logic              m0_pwrite,
  input  logic [DATA_W-1:0] m0_pwdata,
  input  logic [2:0]        m0_pprot,
  output logic [DATA_W-1:0] m0_prdata,
  output logic              m0_pready,
  output logic              m0_pslverr,
  input  logic              m1_psel,
  input  logic              m1_penable,
  input  logic [ADDR_W-1:0] m1_paddr,
  input  logic              m1_pwrite,
  input  logic [DATA_W-1:0] m1_pwdata,
  input  logic [2:0]        m1_pprot,
  output logic [DATA_W-1:0] m1_prdata,
  output logic              m1_pready,
  output logic              m1_pslverr,
  output logic              s_psel,
  output logic              s_penable,
  output logic [ADDR_W-1:0] s_paddr,
  output logic              s_pwrite,
  output logic [DATA_W-1:0] s_pwdata,
  output logic [2:0]        s_pprot,
  input  logic [DATA_W-1:0] s_prdata,
  output logic              sec_viol
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  state_t            state_q, state_d;
  logic              grant_q, grant_d, last_q, last_d, err_q, err_d;
  logic              pwrite_q, pwrite_d, pick;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic [2:0]        pprot_q, pprot_d, pick_prot;
  logic              penable_unused;
  assign penable_unused = m0_penable | m1_penable;
  // pick = 1 selects master 1; on a tie the master that was not granted last wins
  always_comb begin
    pick = (m0_psel & m1_psel) ? ~last_q : m1_psel;
    pick_prot = pick ? m1_pprot : m0_pprot;
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    err_d = err_q;
    paddr_d = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pprot_d = pprot_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (m0_psel | m1_psel) begin
        grant_d = pick;
        last_d = pick;
        paddr_d = pick ? m1_paddr : m0_paddr;
        pwrite_d = pick ? m1_pwrite : m0_pwrite;
        pwdata_d = pick ? m1_pwdata : m0_pwdata;
        pprot_d = pick_prot;
        err_d = tipc_tim_trust & pick_prot[1];
        rdata_d = '0;
        state_d = err_d ? DONE : SETUP;
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        rdata_d = pwrite_q ? '0 : s_prdata;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q <= 1'b1;
      err_q <= 1'b0;
      paddr_q <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pprot_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      err_q <= err_d;
      paddr_q <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pprot_q <= pprot_d;
      rdata_q <= rdata_d;
    end
  // every output decodes flops only, so reset clears them without a clock edge
  assign s_psel = (state_q == SETUP) || (state_q == ACCESS);
  assign s_penable = state_q == ACCESS;
  assign s_paddr = paddr_q;
  assign s_pwrite = pwrite_q;
  assign s_pwdata = pwdata_q;
  assign s_pprot = pprot_q;
  assign m0_pready = (state_q == DONE) && !grant_q;
  assign m1_pready = (state_q == DONE) && grant_q;
  assign m0_pslverr = m0_pready & err_q;
  assign m1_pslverr = m1_pready & err_q;
  assign m0_prdata = m0_pready ? rdata_q : '0;
  assign m1_prdata = m1_pready ? rdata_q : '0;
  assign sec_viol = (state_q == DONE) && err_q;
endmodule

// File: tb/tb_tim_apb_arb.sv
// tb_tim_apb_arb: directed latency/security/reset scenarios plus randomized two-master traffic
// checked against a transaction-level scoreboard of the timer register file.
module tb_tim_apb_arb;
  logic pclk = 1'b0, presetn = 1'b0, trust = 1'b0;
  logic m_psel [2], m_pwrite [2], m_pready [2], m_pslverr [2];
  logic [31:0] m_paddr [2], m_pwdata [2], m_prdata [2];
  logic [2:0] m_pprot [2];
  logic s_psel, s_penable, s_pwrite, sec_viol;
  logic [31:0] s_paddr, s_pwdata, s_prdata;
  logic [2:0] s_pprot;
  logic [31:0] tmem [16];
  logic [31:0] rmem [16];
  int checks = 0, failures = 0;
  always #5 pclk = ~pclk;
  tim_apb_arb dut (
    .pclk(pclk), .presetn(presetn), .tipc_tim_trust(trust),
    .m0_psel(m_psel[0]), .m0_penable(m_psel[0]), .m0_paddr(m_paddr[0]), .m0_pwrite(m_pwrite[0]),
    .m0_pwdata(m_pwdata[0]), .m0_pprot(m_pprot[0]), .m0_prdata(m_prdata[0]), .m0_pready(m_pready[0]),
    .m0_pslverr(m_pslverr[0]),
    .m1_psel(m_psel[1]), .m1_penable(m_psel[1]), .m1_paddr(m_paddr[1]), .m1_pwrite(m_pwrite[1]),
    .m1_pwdata(m_pwdata[1]), .m1_pprot(m_pprot[1]), .m1_prdata(m_prdata[1]), .m1_pready(m_pready[1]),
    .m1_pslverr(m_pslverr[1]),
    .s_psel(s_psel), .s_penable(s_penable), .s_paddr(s_paddr), .s_pwrite(s_pwrite),
    .s_pwdata(s_pwdata), .s_pprot(s_pprot), .s_prdata(s_prdata), .sec_viol(sec_viol)
  );
  // timer slave: zero-wait register file, cleared by reset
  always @(posedge pclk or negedge presetn)
    if (!presetn) for (int k = 0; k < 16; k++) tmem[k] <= '0;
    else if (s_psel && s_penable && s_pwrite) tmem[s_paddr[5:2]] <= s_pwdata;
  assign s_prdata = tmem[s_paddr[5:2]];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic req(input int i, input logic [31:0] a, input logic w, input logic [31:0] d, input logic [2:0] p);
    m_psel[i] = 1'b1;
    m_paddr[i] = a;
    m_pwrite[i] = w;
    m_pwdata[i] = d;
    m_pprot[i] = p;
  endtask
  task automatic do_reset();
    presetn = 1'b0;
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
  endtask
  task automatic xfer(input int i, input logic [31:0] a, input logic w, input logic [31:0] d, input logic [2:0] p,
                      output int lat, output logic [31:0] rd, output logic err, output logic sv, output logic oth,
                      output logic saw);
    req(i, a, w, d, p);
    lat = 0;
    saw = 1'b0;
    rd = '0;
    err = 1'b0;
    sv = 1'b0;
    oth = 1'b0;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(negedge pclk);
      if (s_psel) saw = 1'b1;
      if (m_pready[i]) begin
        lat = c;
        rd = m_prdata[i];
        err = m_pslverr[i];
        sv = sec_viol;
        oth = m_pready[1-i] | m_pslverr[1-i] | (|m_prdata[1-i]);
      end
    end
    m_psel[i] = 1'b0;
    @(negedge pclk);
  endtask
  // Scoreboard: every access gets err = trust & pprot[1]; allowed writes update rmem, allowed
  // reads must return rmem; a master completing while the other waits must be followed by the other.
  task automatic rand_run(input logic tr, input int ncyc);
    int must, setups, allowed;
    int age [2];
    logic e;
    logic [3:0] idx;
    must = -1;
    setups = 0;
    allowed = 0;
    age[0] = 0;
    age[1] = 0;
    trust = tr;
    for (int k = 0; k < 16; k++) rmem[k] = '0;
    for (int c = 0; c < ncyc + 40; c++) begin
      @(negedge pclk);
      if (s_psel && !s_penable) setups++;
      for (int i = 0; i < 2; i++) begin
        idx = m_paddr[i][5:2];
        if (m_psel[i] && m_pready[i]) begin
          e = tr & m_pprot[i][1];
          if (must >= 0) chk("rr_order", i, must);
          chk("slverr", m_pslverr[i], e);
          chk("sec_viol", sec_viol, e);
          chk("other_rdy", m_pready[1-i], 1'b0);
          if (!e) begin
            allowed++;
            if (m_pwrite[i]) begin
              chk("wr_rdata", m_prdata[i], 0);
              rmem[idx] = m_pwdata[i];
            end else chk("rd_data", m_prdata[i], rmem[idx]);
          end
          must = m_psel[1-i] ? 1 - i : -1;
          m_psel[i] = 1'b0;
          age[i] = 0;
        end else if (m_psel[i]) begin
          age[i]++;
          if (age[i] > 20) begin
            chk("wait_timeout", age[i], 20);
            m_psel[i] = 1'b0;
            age[i] = 0;
          end
        end
        if (c < ncyc && !m_psel[i] && $urandom_range(0, 3) == 0)
          req(i, $urandom & 32'h3C, 1'($urandom), $urandom, 3'($urandom));
      end
    end
    chk("setup_count", setups, allowed);
  endtask
  int lat, k;
  logic [31:0] rd;
  logic err, sv, oth, saw;
  initial begin
    for (int i = 0; i < 2; i++) begin
      m_psel[i] = 1'b0;
      m_paddr[i] = '0;
      m_pwrite[i] = 1'b0;
      m_pwdata[i] = '0;
      m_pprot[i] = '0;
    end
    @(negedge pclk);
    chk("rst_psel", s_psel, 0);
    chk("rst_penable", s_penable, 0);
    chk("rst_paddr", s_paddr, 0);
    chk("rst_pprot", s_pprot, 0);
    chk("rst_rdy0", m_pready[0], 0);
    chk("rst_rdy1", m_pready[1], 0);
    chk("rst_sv", sec_viol, 0);
    presetn = 1'b1;
    // tie from reset: m0 first, then strict alternation every 4 cycles
    req(0, 32'h0, 1'b0, 32'h0, 3'b000);
    req(1, 32'h0, 1'b0, 32'h0, 3'b000);
    k = 0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge pclk);
      for (int i = 0; i < 2; i++)
        if (m_pready[i]) begin
          chk("tie_id", i, k % 2);
          chk("tie_cyc", c, 3 + 4 * k);
          k++;
        end
    end
    chk("tie_count", k, 6);
    m_psel[0] = 1'b0;
    m_psel[1] = 1'b0;
    @(negedge pclk);
    // m0 secure write with trust set
    trust = 1'b1;
    req(0, 32'h08, 1'b1, 32'h1234, 3'b000);
    @(negedge pclk);
    chk("w_setup_psel", s_psel, 1);
    chk("w_setup_pen", s_penable, 0);
    chk("w_setup_addr", s_paddr, 32'h08);
    @(negedge pclk);
    chk("w_acc_pen", s_penable & s_psel, 1);
    chk("w_acc_wdata", s_pwdata, 32'h1234);
    chk("w_acc_write", s_pwrite, 1);
    @(negedge pclk);
    chk("w_rdy", m_pready[0], 1);
    chk("w_err", m_pslverr[0], 0);
    m_psel[0] = 1'b0;
    @(negedge pclk);
    chk("w_rdy_pulse", m_pready[0], 0);
    xfer(0, 32'h04, 1'b1, 32'hDEADBEEF, 3'b000, lat, rd, err, sv, oth, saw);
    chk("pre_lat", lat, 3);
    // m1 read
    xfer(1, 32'h04, 1'b0, 32'h0, 3'b000, lat, rd, err, sv, oth, saw);
    chk("r_lat", lat, 3);
    chk("r_data", rd, 32'hDEADBEEF);
    chk("r_m0_quiet", oth, 0);
    // blocked non-secure write, then same access with trust cleared
    xfer(1, 32'h0C, 1'b1, 32'h55, 3'b010, lat, rd, err, sv, oth, saw);
    chk("blk_lat", lat, 1);
    chk("blk_err", err, 1);
    chk("blk_sv", sv, 1);
    chk("blk_no_psel", saw, 0);
    chk("blk_sv_pulse", sec_viol, 0);
    trust = 1'b0;
    xfer(1, 32'h0C, 1'b1, 32'h55, 3'b010, lat, rd, err, sv, oth, saw);
    chk("ns_lat", lat, 3);
    chk("ns_err", err, 0);
    chk("ns_sv", sv, 0);
    chk("ns_psel", saw, 1);
    // trust rising during SETUP does not affect the transfer in flight
    req(0, 32'h10, 1'b1, 32'hA5, 3'b010);
    @(negedge pclk);
    chk("t6_setup", s_psel & ~s_penable, 1);
    trust = 1'b1;
    @(negedge pclk);
    @(negedge pclk);
    chk("t6_rdy", m_pready[0], 1);
    chk("t6_err", m_pslverr[0], 0);
    chk("t6_sv", sec_viol, 0);
    m_psel[0] = 1'b0;
    trust = 1'b0;
    @(negedge pclk);
    // async reset during ACCESS; last grant was m0, reset must restore m0 priority
    req(0, 32'h0, 1'b0, 32'h0, 3'b000);
    @(negedge pclk);
    @(negedge pclk);
    chk("rst_acc_pen", s_penable, 1);
    #2 presetn = 1'b0;
    #1;
    chk("arst_psel", s_psel, 0);
    chk("arst_pen", s_penable, 0);
    chk("arst_rdy", m_pready[0] | m_pready[1], 0);
    m_psel[0] = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
    req(0, 32'h0, 1'b0, 32'h0, 3'b000);
    req(1, 32'h0, 1'b0, 32'h0, 3'b000);
    k = -1;
    for (int c = 1; c <= 10 && k < 0; c++) begin
      @(negedge pclk);
      if (m_pready[0] | m_pready[1]) begin
        k = m_pready[1] ? 1 : 0;
        chk("post_rst_cyc", c, 3);
      end
    end
    chk("post_rst_tie", k, 0);
    m_psel[0] = 1'b0;
    m_psel[1] = 1'b0;
    @(negedge pclk);
    do_reset();
    rand_run(1'b0, 400);
    do_reset();
    rand_run(1'b1, 400);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tim_apb_arb.md
Name: tim_apb_arb

Overview:
- Two-requester APB arbiter and security filter placed in front of a timer's APB slave port.
- Shares the single timer slave between master 0 and master 1 using round-robin arbitration.
- Inserts the setup/access sequencing toward the timer, which is a zero-wait-state slave with no pready.
- Blocks non-secure accesses when the timer is marked trusted by the TIPC, and returns an error response for them.

Parameters:
ADDR_W, 32, address width on all ports
DATA_W, 32, data width on all ports

Ports:
pclk  in  1  APB clock; the only clock
presetn  in  1  asynchronous active-low reset
tipc_tim_trust  in  1  1 = timer is secure-only
m0_psel  in  1  master 0 select; held until m0_pready
m0_penable  in  1  master 0 enable (ignored for arbitration)
m0_paddr  in  ADDR_W  master 0 address
m0_pwrite  in  1  master 0 write
m0_pwdata  in  DATA_W  master 0 write data
m0_pprot  in  3  master 0 protection; bit1 = 1 means non-secure
m0_prdata  out  DATA_W  master 0 read data
m0_pready  out  1  master 0 transfer done
m0_pslverr  out  1  master 0 error
m1_*  same set as m0_*  master 1
s_psel  out  1  timer select
s_penable  out  1  timer enable
s_paddr  out  ADDR_W  timer address
s_pwrite  out  1  timer write
s_pwdata  out  DATA_W  timer write data
s_pprot  out  3  timer protection
s_prdata  in  DATA_W  timer read data, valid in access phase
sec_viol  out  1  one-cycle pulse on a blocked access

Behaviour:
- Single clock pclk. Reset presetn is asynchronous, active-low.
- Reset values:
  - All outputs 0.
  - FSM = IDLE.
  - last_grant = 1, so master 0 wins the first tie.
  - Captured address, data and protection registers = 0.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - A request is mX_psel = 1.
  - One requester: grant it.
  - Both requesting: grant the one that is not last_grant, then update last_grant.
  - On grant, register the master's paddr, pwrite, pwdata and pprot into the s_* holding registers and latch grant_id.
  - Evaluate block = tipc_tim_trust & pprot[1] in the same cycle.
  - block = 0: go to SETUP.
  - block = 1: go to DONE with err = 1; the timer is never selected.
- SETUP: s_psel = 1, s_penable = 0. Go to ACCESS.
- ACCESS:
  - s_psel = 1, s_penable = 1.
  - The timer completes in this cycle.
  - Capture s_prdata into rdata_q on a read; on a write, rdata_q = 0.
  - Go to DONE.
- DONE:
  - Granted master sees mX_pready = 1, mX_prdata = rdata_q and mX_pslverr = err for exactly one cycle.
  - sec_viol = err.
  - s_psel = 0. Go to IDLE.
- Latency, with the request first seen in IDLE at cycle T:
  - Allowed access: s_psel rises at T+1, s_penable at T+2, pready at T+3.
  - Blocked access: pready and pslverr at T+1.
- Minimum one IDLE cycle between transfers. Peak rate is one transfer per 4 cycles.
- Outputs toward the non-granted master: pready = 0, pslverr = 0, prdata = 0.
- All s_* outputs and m*_ response outputs are registered; no combinational path from m* inputs to s_* outputs.
- s_* address, write, wdata and prot are held stable from SETUP through ACCESS. They keep their value in IDLE but are qualified by s_psel = 0.
- tipc_tim_trust is sampled only in IDLE at grant; a change mid-transfer does not affect the transfer in flight.
- If the granted master drops psel before pready (protocol violation), the transfer still completes downstream and pready is still pulsed. No abort.
- A waiting master keeps psel high. It is granted at the next IDLE, so there is no starvation: at most one transfer of the other master in between.
- Reset asserted mid-transfer: all outputs clear immediately and asynchronously, s_psel drops, and the transfer is lost.
- No state beyond FSM, grant_id, last_grant, err, rdata_q and the holding registers.

Test Plan:
- m0 write, addr 0x08, data 0x1234, pprot = 3'b000, trust = 1 -> s_psel at T+1, s_penable at T+2 with s_pwdata = 0x1234; m0_pready at T+3 with pslverr = 0.
- m1 read, addr 0x04, s_prdata = 0xDEADBEEF in ACCESS -> m1_prdata = 0xDEADBEEF and m1_pready at T+3; m0 outputs all 0.
- m0 and m1 both request from reset -> m0 served first, m1 second (pready at T+3 and T+7), then alternating over 6 back-to-back requests.
- m1 write, pprot = 3'b010, trust = 1 -> s_psel never asserts; m1_pready = 1, m1_pslverr = 1, sec_viol = 1 at T+1. Same access with trust = 0 -> normal transfer.
- presetn pulled low during ACCESS -> s_psel, s_penable and all pready outputs go to 0 without waiting for a clock edge; after release, the first tie goes to m0.
- trust toggles 0->1 during SETUP of a non-secure access -> the transfer completes with pslverr = 0.
